// File: rtl/lemming_pkg.sv
// lemming_pkg: shared state encoding and fall-counter sizing for the lemming channels.
package lemming_pkg;
  typedef enum logic [2:0] {
    WALK_L,
    WALK_R,
    FALL_L,
    FALL_R,
    DIG_L,
    DIG_R,
    SPLAT
  } lem_state_t;
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction
endpackage

// File: rtl/lemming_unit.sv
// lemming_unit: one lemming channel, a Moore FSM with a saturating fall-duration counter.
module lemming_unit
  import lemming_pkg::*;
#(
  parameter int SPLAT_CYCLES = 20
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic alive
);
  localparam int CW = cnt_width(SPLAT_CYCLES);
  localparam logic [CW-1:0] SAT = CW'(SPLAT_CYCLES);
  lem_state_t state, state_next;
  logic [CW-1:0] fall_cnt, fall_cnt_next;
  logic falling, too_long;
  assign falling  = (state == FALL_L) || (state == FALL_R);
  assign too_long = fall_cnt == SAT;
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state    <= WALK_L;
      fall_cnt <= '0;
    end else begin
      state    <= state_next;
      fall_cnt <= fall_cnt_next;
    end
  // Saturating at SAT keeps arbitrarily long falls from wrapping back to survivable.
  always_comb begin
    fall_cnt_next = falling ? (too_long ? fall_cnt : fall_cnt + CW'(1)) : '0;
    state_next    = state;
    case (state)
      WALK_L:  state_next = !ground ? FALL_L : dig ? DIG_L : bump_left ? WALK_R : WALK_L;
      WALK_R:  state_next = !ground ? FALL_R : dig ? DIG_R : bump_right ? WALK_L : WALK_R;
      FALL_L:  state_next = !ground ? FALL_L : too_long ? SPLAT : WALK_L;
      FALL_R:  state_next = !ground ? FALL_R : too_long ? SPLAT : WALK_R;
      DIG_L:   state_next = !ground ? FALL_L : DIG_L;
      DIG_R:   state_next = !ground ? FALL_R : DIG_R;
      SPLAT:   state_next = SPLAT;
      default: state_next = WALK_L;
    endcase
  end
  always_comb begin
    walk_left  = state == WALK_L;
    walk_right = state == WALK_R;
    aaah       = falling;
    digging    = (state == DIG_L) || (state == DIG_R);
    alive      = state != SPLAT;
  end
endmodule

// File: rtl/lemming_array.sv
// lemming_array: N_LEM independent lemming channels plus a live-channel population count.
module lemming_array
  import lemming_pkg::*;
#(
  parameter int N_LEM        = 4,
  parameter int SPLAT_CYCLES = 20
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [N_LEM-1:0]             bump_left,
  input  logic [N_LEM-1:0]             bump_right,
  input  logic [N_LEM-1:0]             ground,
  input  logic [N_LEM-1:0]             dig,
  output logic [N_LEM-1:0]             walk_left,
  output logic [N_LEM-1:0]             walk_right,
  output logic [N_LEM-1:0]             aaah,
  output logic [N_LEM-1:0]             digging,
  output logic [$clog2(N_LEM+1)-1:0]   alive_count
);
  localparam int AW = $clog2(N_LEM + 1);
  logic [N_LEM-1:0] alive;
  for (genvar i = 0; i < N_LEM; i++) begin : g_lem
    lemming_unit #(.SPLAT_CYCLES(SPLAT_CYCLES)) u_lem (
      .clk(clk),
      .areset(areset),
      .bump_left(bump_left[i]),
      .bump_right(bump_right[i]),
      .ground(ground[i]),
      .dig(dig[i]),
      .walk_left(walk_left[i]),
      .walk_right(walk_right[i]),
      .aaah(aaah[i]),
      .digging(digging[i]),
      .alive(alive[i])
    );
  end
  always_comb begin
    alive_count = '0;
    for (int k = 0; k < N_LEM; k++) alive_count = alive_count + AW'(alive[k]);
  end
endmodule

// File: tb/tb_lemming_array.sv
// tb_lemming_array: directed scenarios plus randomized traffic against a behavioural lemming model.
module tb_lemming_array;
  localparam int N = 4;
  localparam int SC = 20;
  logic clk = 0, areset = 1;
  logic [N-1:0] bump_left = '0, bump_right = '0, ground = '1, dig = '0;
  logic [N-1:0] walk_left, walk_right, aaah, digging;
  logic [2:0] alive_count;
  int passed = 0, total = 0;
  int mode[N];  // 0 walking, 1 falling, 2 digging, 3 dead
  bit dir[N];   // 1 = heading right
  int ft[N];    // cycles spent falling so far
  int hole[N];

  lemming_array #(.N_LEM(N), .SPLAT_CYCLES(SC)) dut (
    .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(walk_left), .walk_right(walk_right),
    .aaah(aaah), .digging(digging), .alive_count(alive_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = 0;
      dir[i] = 0;
      ft[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [N-1:0] bl, br, gd, dg);
    for (int i = 0; i < N; i++)
      case (mode[i])
        0: if (!gd[i]) begin mode[i] = 1; ft[i] = 1; end
           else if (dg[i]) mode[i] = 2;
           else if (dir[i] ? br[i] : bl[i]) dir[i] = !dir[i];
        1: if (!gd[i]) ft[i]++;
           else mode[i] = (ft[i] > SC) ? 3 : 0;
        2: if (!gd[i]) begin mode[i] = 1; ft[i] = 1; end
        default: ;
      endcase
  endfunction

  task automatic compare_all(input string tag);
    logic [N-1:0] ewl, ewr, ea, ed;
    int live;
    live = 0;
    for (int i = 0; i < N; i++) begin
      ewl[i] = mode[i] == 0 && !dir[i];
      ewr[i] = mode[i] == 0 && dir[i];
      ea[i]  = mode[i] == 1;
      ed[i]  = mode[i] == 2;
      live += (mode[i] != 3) ? 1 : 0;
    end
    check({tag, ".walk_left"}, walk_left, ewl);
    check({tag, ".walk_right"}, walk_right, ewr);
    check({tag, ".aaah"}, aaah, ea);
    check({tag, ".digging"}, digging, ed);
    check({tag, ".alive_count"}, alive_count, live);
  endtask

  task automatic step(input string tag, input logic [N-1:0] bl, br, gd, dg);
    bump_left = bl;
    bump_right = br;
    ground = gd;
    dig = dg;
    @(posedge clk);
    model_edge(bl, br, gd, dg);
    #1 compare_all(tag);
  endtask

  // Pulses reset between edges and checks the outputs recover before any edge.
  task automatic async_reset(input string tag);
    #2 areset = 1;
    #1 model_reset();
    check({tag, ".rst_wl"}, walk_left, 4'hf);
    check({tag, ".rst_alive"}, alive_count, 4);
    compare_all(tag);
    #1 areset = 0;
    #1 compare_all({tag, ".post"});
  endtask

  initial begin
    logic [N-1:0] bl, br, gd, dg;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.walk_left", walk_left, 4'hf);
    check("reset.alive", alive_count, 4);
    compare_all("reset");
    areset = 0;
    step("bump0", 4'b0001, 0, 4'hf, 0);
    check("bump0.ch0_right", walk_right[0], 1);
    check("bump0.others_left", walk_left[3:1], 3'b111);
    step("bump_both1", 4'b0010, 4'b0010, 4'hf, 0);
    check("bump_both1.ch1_right", walk_right[1], 1);
    for (int k = 0; k < 20; k++) begin
      step("fall20", 0, 0, 4'b1011, 0);
      check("fall20.aaah2", aaah[2], 1);
    end
    step("land20", 0, 0, 4'hf, 0);
    check("land20.ch2_left", walk_left[2], 1);
    for (int k = 0; k < 21; k++) step("fall21", 0, 0, 4'b1011, 0);
    step("land21", 0, 0, 4'hf, 0);
    check("land21.ch2_dead", {walk_left[2], walk_right[2], aaah[2], digging[2]}, 0);
    check("land21.alive", alive_count, 3);
    step("ch3_turn", 4'b1000, 0, 4'hf, 0);
    step("ch3_dig", 0, 0, 4'hf, 4'b1000);
    check("ch3_dig.digging", digging[3], 1);
    for (int k = 0; k < 5; k++) begin
      step("ch3_fall", 4'b1000, 4'b1000, 4'b0111, 4'b1000);
      check("ch3_fall.aaah", aaah[3], 1);
    end
    step("ch3_land", 0, 0, 4'hf, 0);
    check("ch3_land.right", walk_right[3], 1);
    check("ch3_land.not_dig", digging[3], 0);
    step("ch0_turn", 0, 4'b0001, 4'hf, 0);
    step("ch0_fall", 4'b0001, 0, 4'b1110, 4'b0001);
    check("ch0_fall.aaah", aaah[0], 1);
    for (int k = 0; k < 299; k++) begin
      bl = N'($urandom);
      br = N'($urandom);
      step("long_fall", bl, br, 4'b1110, 0);
    end
    check("long_fall.still_falling", aaah[0], 1);
    step("long_land", 0, 0, 4'hf, 0);
    check("long_land.alive", alive_count, 2);
    check("long_land.ch0_dead", {walk_left[0], walk_right[0], aaah[0], digging[0]}, 0);
    async_reset("areset_mid");
    for (int i = 0; i < N; i++) hole[i] = 0;
    for (int s = 0; s < 2000; s++) begin
      for (int i = 0; i < N; i++) begin
        if (hole[i] > 0) begin
          gd[i] = 0;
          hole[i]--;
        end else begin
          gd[i] = 1;
          if ($urandom_range(0, 19) == 0) hole[i] = $urandom_range(1, 30);
        end
        dg[i] = $urandom_range(0, 7) == 0;
      end
      bl = N'($urandom);
      br = N'($urandom);
      step("rand", bl, br, gd, dg);
      if (s % 250 == 249) async_reset("rand_rst");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
